fetch_queue: RTL and testbench

- Parametrised instruction queue that decouples the fetch stage from the pre-decode stage.
- Accepts up to FETCH_WIDTH lanes per cycle from the i-cache/branch-predictor output.
- Squashes lanes younger than the first predicted-taken lane, compacts the survivors and stores them in a circular buffer.
- Presents up to DECODE_WIDTH oldest entries per cycle to pre-decode, so an i-cache miss or decode back-pressure no longer stalls both stages in lockstep.

---
 rtl/fetch_queue_if.sv | 45 ++++
 rtl/fetch_queue.sv | 131 +++++++++++++
 tb/tb_fetch_queue.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_queue_if.sv
// ============================================================================
// Module      : fetch_queue_if
// Description : Fetch-group input, pre-decode output and status signals of
//               the fetch queue, bundled with producer/consumer views.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface fetch_queue_if #(
  parameter int FETCH_WIDTH  = 2,
  parameter int DECODE_WIDTH = 2,
  parameter int DEPTH        = 8,
  parameter int INSN_WIDTH   = 32,
  parameter int PC_WIDTH     = 32,
  parameter int PRED_WIDTH   = 64
);
  logic                               flush;
  logic [FETCH_WIDTH-1:0]             in_valid;
  logic [FETCH_WIDTH-1:0]             in_taken;
  logic [FETCH_WIDTH*PC_WIDTH-1:0]    in_pc;
  logic [FETCH_WIDTH*INSN_WIDTH-1:0]  in_insn;
  logic [FETCH_WIDTH*PRED_WIDTH-1:0]  in_pred;
  logic                               in_ready;
  logic [DECODE_WIDTH-1:0]            out_valid;
  logic [DECODE_WIDTH*PC_WIDTH-1:0]   out_pc;
  logic [DECODE_WIDTH*INSN_WIDTH-1:0] out_insn;
  logic [DECODE_WIDTH*PRED_WIDTH-1:0] out_pred;
  logic                               out_ready;
  logic [$clog2(DEPTH):0]             occupancy;
  logic [$clog2(FETCH_WIDTH):0]       squashed;

  // Pipeline side: drives fetch groups, flush and pre-decode ready
  modport master (
    output flush, in_valid, in_taken, in_pc, in_insn, in_pred, out_ready,
    input  in_ready, out_valid, out_pc, out_insn, out_pred, occupancy, squashed
  );

  // Queue side
  modport slave (
    input  flush, in_valid, in_taken, in_pc, in_insn, in_pred, out_ready,
    output in_ready, out_valid, out_pc, out_insn, out_pred, occupancy, squashed
  );
endinterface

`default_nettype wire

// File: rtl/fetch_queue.sv
// ============================================================================
// Module      : fetch_queue
// Description : Circular instruction queue between fetch and pre-decode.
//               Squashes lanes younger than the first predicted-taken lane,
//               compacts survivors and presents the oldest entries.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_queue #(
  parameter int FETCH_WIDTH  = 2,
  parameter int DECODE_WIDTH = 2,
  parameter int DEPTH        = 8,
  parameter int INSN_WIDTH   = 32,
  parameter int PC_WIDTH     = 32,
  parameter int PRED_WIDTH   = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  fetch_queue_if.slave bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int SQ_W  = $clog2(FETCH_WIDTH) + 1;

  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             ready_en_q;

  logic [PC_WIDTH-1:0]   pc_mem_q   [DEPTH];
  logic [INSN_WIDTH-1:0] insn_mem_q [DEPTH];
  logic [PRED_WIDTH-1:0] pred_mem_q [DEPTH];

  logic [FETCH_WIDTH-1:0] surv;
  logic [SQ_W-1:0]        slot_off [FETCH_WIDTH];
  logic [SQ_W-1:0]        n_surv;
  logic [SQ_W-1:0]        n_sq;
  logic                   taken_seen;
  logic                   do_enq;
  logic                   do_deq;
  logic [SQ_W-1:0]        n_enq;
  logic [CNT_W-1:0]       n_deq;

  // Free-space check uses registered count only; gated until out of reset
  assign bus.in_ready = ready_en_q &&
                        ((CNT_W'(DEPTH) - count_q) >= CNT_W'(FETCH_WIDTH));

  // Keep lanes up to and including the first valid-taken lane; each
  // survivor's slot offset is the number of survivors below it
  always_comb begin
    taken_seen = 1'b0;
    surv       = '0;
    n_surv     = '0;
    n_sq       = '0;
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      slot_off[i] = n_surv;
      if (bus.in_valid[i]) begin
        if (taken_seen) begin
          n_sq = n_sq + SQ_W'(1);
        end else begin
          surv[i] = 1'b1;
          n_surv  = n_surv + SQ_W'(1);
        end
        if (bus.in_taken[i]) taken_seen = 1'b1;
      end
    end
  end

  assign do_enq       = bus.in_ready && (|bus.in_valid) && !bus.flush;
  assign do_deq       = bus.out_ready && !bus.flush;
  assign n_enq        = do_enq ? n_surv : '0;
  assign n_deq        = !do_deq ? '0 :
                        (count_q > CNT_W'(DECODE_WIDTH)) ? CNT_W'(DECODE_WIDTH) : count_q;
  assign bus.squashed = do_enq ? n_sq : '0;
  assign bus.occupancy = count_q;

  // Next-state pointers/count; flush overrides any same-cycle traffic
  always_comb begin
    head_d  = head_q + PTR_W'(n_deq);
    tail_d  = tail_q + PTR_W'(n_enq);
    count_d = count_q + CNT_W'(n_enq) - n_deq;
    if (bus.flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  // Queue control state with asynchronous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      ready_en_q <= 1'b0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      ready_en_q <= 1'b1;
    end
  end

  // Entry storage: survivors written contiguously from tail, modulo DEPTH
  always_ff @(posedge clk) begin
    if (do_enq) begin
      for (int i = 0; i < FETCH_WIDTH; i++) begin
        if (surv[i]) begin
          pc_mem_q[tail_q + PTR_W'(slot_off[i])]   <= bus.in_pc[i*PC_WIDTH +: PC_WIDTH];
          insn_mem_q[tail_q + PTR_W'(slot_off[i])] <= bus.in_insn[i*INSN_WIDTH +: INSN_WIDTH];
          pred_mem_q[tail_q + PTR_W'(slot_off[i])] <= bus.in_pred[i*PRED_WIDTH +: PRED_WIDTH];
        end
      end
    end
  end

  // Output lane j shows the j-th oldest entry
  for (genvar j = 0; j < DECODE_WIDTH; j++) begin : g_out_lane
    logic [PTR_W-1:0] rd_idx;
    assign rd_idx = head_q + PTR_W'(j);
    assign bus.out_valid[j] = (count_q > CNT_W'(j));
    assign bus.out_pc[j*PC_WIDTH +: PC_WIDTH]       = pc_mem_q[rd_idx];
    assign bus.out_insn[j*INSN_WIDTH +: INSN_WIDTH] = insn_mem_q[rd_idx];
    assign bus.out_pred[j*PRED_WIDTH +: PRED_WIDTH] = pred_mem_q[rd_idx];
  end

endmodule

`default_nettype wire

// File: tb/tb_fetch_queue.sv
// ============================================================================
// Module      : tb_fetch_queue
// Description : Scoreboard bench for fetch_queue with directed and random
//               fetch groups, flushes and asynchronous reset.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fetch_queue;

  logic clk;
  logic rst_n;

  fetch_queue_if #(
    .FETCH_WIDTH(2), .DECODE_WIDTH(2), .DEPTH(8),
    .INSN_WIDTH(32), .PC_WIDTH(32), .PRED_WIDTH(64)
  ) bus ();

  fetch_queue #(
    .FETCH_WIDTH(2), .DECODE_WIDTH(2), .DEPTH(8),
    .INSN_WIDTH(32), .PC_WIDTH(32), .PRED_WIDTH(64)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] insn;
    logic [63:0] pred;
  } entry_t;

  // Reference model: queue contents in age order plus expected count
  entry_t exp_q[$];
  int     m_cnt = 0;
  bit     m_en  = 0;
  int     m_enq = 0;
  int     m_sq  = 0;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] pc_ctr;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  // Issue one fetch group and record its expected survivors in the scoreboard
  task automatic drive(input logic [1:0] v, input logic [1:0] t, input logic fl,
                       input logic ordy, input logic [31:0] pc0, input logic [31:0] pc1);
    entry_t e [2];
    bit     stop;
    bit     acc;
    int     sq;
    int     ne;
    @(posedge clk);
    #1;
    e[0].pc = pc0;
    e[1].pc = pc1;
    for (int i = 0; i < 2; i++) begin
      e[i].insn = $urandom;
      e[i].pred = {$urandom, $urandom};
    end
    bus.in_valid  = v;
    bus.in_taken  = t;
    bus.flush     = fl;
    bus.out_ready = ordy;
    bus.in_pc     = {e[1].pc, e[0].pc};
    bus.in_insn   = {e[1].insn, e[0].insn};
    bus.in_pred   = {e[1].pred, e[0].pred};
    acc  = m_en && ((8 - m_cnt) >= 2) && (v != 2'b00) && !fl;
    sq   = 0;
    ne   = 0;
    stop = 0;
    if (acc) begin
      for (int i = 0; i < 2; i++) begin
        if (v[i]) begin
          if (stop) sq++;
          else begin
            exp_q.push_back(e[i]);
            ne++;
            if (t[i]) stop = 1;
          end
        end
      end
    end
    m_enq = ne;
    m_sq  = sq;
  endtask

  task automatic idle(input logic ordy);
    drive(2'b00, 2'b00, 1'b0, ordy, 32'h0, 32'h0);
  endtask

  task automatic rand_group();
    logic [1:0] v;
    logic [1:0] t;
    v = 2'($urandom);
    t = {($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0)};
    drive(v, t, ($urandom_range(0, 24) == 0), 1'($urandom), pc_ctr, pc_ctr + 32'd4);
    pc_ctr = pc_ctr + 32'd8;
  endtask

  // Asynchronous reset pulse mid-cycle; outputs must clear without an edge
  task automatic do_reset();
    @(posedge clk);
    #2;
    bus.in_valid  = '0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b0;
    m_enq = 0;
    m_sq  = 0;
    rst_n = 1'b0;
    #1;
    chk("async_rst_occupancy", 64'(bus.occupancy), 64'd0);
    chk("async_rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("async_rst_in_ready",  64'(bus.in_ready),  64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Monitor: compare presented lanes against scoreboard, pop what is consumed
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_occupancy", 64'(bus.occupancy), 64'd0);
      chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
      chk("rst_in_ready",  64'(bus.in_ready),  64'd0);
      exp_q.delete();
      m_cnt = 0;
      m_en  = 0;
    end else begin
      chk("in_ready",  64'(bus.in_ready),  64'(m_en && ((8 - m_cnt) >= 2)));
      chk("occupancy", 64'(bus.occupancy), 64'(m_cnt));
      chk("out_valid", 64'(bus.out_valid), {62'd0, (m_cnt > 1), (m_cnt > 0)});
      chk("squashed",  64'(bus.squashed),  64'(m_sq));
      for (int j = 0; j < 2; j++) begin
        if (m_cnt > j && exp_q.size() > j) begin
          chk("out_pc",   64'(bus.out_pc[j*32 +: 32]),   64'(exp_q[j].pc));
          chk("out_insn", 64'(bus.out_insn[j*32 +: 32]), 64'(exp_q[j].insn));
          chk("out_pred", bus.out_pred[j*64 +: 64],      exp_q[j].pred);
        end
      end
      if (bus.flush) begin
        exp_q.delete();
        m_cnt = 0;
      end else begin
        int nd;
        nd = bus.out_ready ? ((m_cnt < 2) ? m_cnt : 2) : 0;
        for (int k = 0; k < nd; k++) void'(exp_q.pop_front());
        m_cnt = m_cnt + m_enq - nd;
      end
      m_en = 1;
    end
  end

  initial begin
    rst_n         = 1'b0;
    bus.flush     = 1'b0;
    bus.in_valid  = '0;
    bus.in_taken  = '0;
    bus.in_pc     = '0;
    bus.in_insn   = '0;
    bus.in_pred   = '0;
    bus.out_ready = 1'b0;
    pc_ctr        = 32'h1000;

    do_reset();
    idle(1'b0);

    // Two plain lanes, held in the queue
    drive(2'b11, 2'b00, 1'b0, 1'b0, 32'h100, 32'h104);
    idle(1'b0);
    idle(1'b1);
    idle(1'b1);

    // Taken lane 0 squashes lane 1
    drive(2'b11, 2'b01, 1'b0, 1'b0, 32'h200, 32'h204);
    idle(1'b1);
    idle(1'b1);

    // Lane 1 only: compacted into slot 0
    drive(2'b10, 2'b00, 1'b0, 1'b0, 32'h300, 32'h304);
    idle(1'b0);
    idle(1'b1);

    // Fill to capacity with decode stalled, then drain
    drive(2'b00, 2'b00, 1'b1, 1'b0, 32'h0, 32'h0);
    for (int g = 0; g < 3; g++) drive(2'b11, 2'b00, 1'b0, 1'b0, 32'h400 + g*8, 32'h404 + g*8);
    drive(2'b01, 2'b00, 1'b0, 1'b0, 32'h420, 32'h424);
    drive(2'b11, 2'b00, 1'b0, 1'b0, 32'h430, 32'h434);
    drive(2'b01, 2'b00, 1'b0, 1'b0, 32'h440, 32'h444);
    for (int g = 0; g < 5; g++) idle(1'b1);

    // 20 back-to-back groups with decode always ready, across pointer wraps
    for (int g = 0; g < 20; g++) begin
      drive(2'b11, 2'b00, 1'b0, 1'b1, pc_ctr, pc_ctr + 32'd4);
      pc_ctr = pc_ctr + 32'd8;
    end
    for (int g = 0; g < 3; g++) idle(1'b1);

    // Flush at count 5 with a simultaneous full group
    drive(2'b11, 2'b00, 1'b0, 1'b0, 32'h500, 32'h504);
    drive(2'b11, 2'b00, 1'b0, 1'b0, 32'h508, 32'h50c);
    drive(2'b01, 2'b00, 1'b0, 1'b0, 32'h510, 32'h514);
    drive(2'b11, 2'b00, 1'b1, 1'b1, 32'h518, 32'h51c);
    idle(1'b0);

    // Random traffic with an asynchronous reset in the middle
    for (int c = 0; c < 150; c++) rand_group();
    do_reset();
    for (int c = 0; c < 250; c++) rand_group();
    for (int c = 0; c < 6; c++) idle(1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
